spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- SPI-mode-0 master that issues a standard READ (0x03) to the external SPI flash and streams the returned bytes out on a valid/ready byte interface.
- Sits between the SoC (boot/data loader) and the flash pins o_flash_ss / o_flash_sck / o_flash_mosi / i_flash_miso.
- In simulation its pins connect to the spiflash model; on silicon they connect to the board flash.

Parameters:
- CLK_DIV, 2, i_clk cycles per SCK half-period (>=1)
- LEN_W, 16, width of the byte-count input
- SS_IDLE, 4, minimum i_clk cycles SS stays high after a transaction before o_busy drops

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle request; sampled only when o_busy=0
- i_addr  input  24  flash byte start address
- i_len  input  LEN_W  number of bytes to read
- o_busy  output  1  transaction in progress
- o_done  output  1  one-cycle pulse at transaction end
- o_data  output  8  read byte
- o_valid  output  1  o_data valid
- i_ready  input  1  consumer accepts o_data when o_valid&i_ready
- o_flash_ss  output  1  chip select, active low
- o_flash_sck  output  1  SPI clock, idle low
- o_flash_mosi  output  1  master out
- i_flash_miso  input  1  master in

Behaviour:
- Reset (async, i_rst_n=0), effective immediately, including mid-transaction: o_flash_ss=1, o_flash_sck=0, o_flash_mosi=0, o_busy=0, o_done=0, o_valid=0, o_data=0x00; FSM to IDLE; no byte from an aborted read is ever presented.
- FSM states: IDLE, CMD, ADDR, DATA, HOLD, TAIL, GAP.
- IDLE:
  - i_start=1 with i_len!=0 latches i_addr and i_len.
  - Next cycle: o_busy=1, o_flash_ss=0, o_flash_mosi=bit7 of 0x03; enter CMD.
  - i_start with i_len=0: o_busy stays 0, o_done pulses the next cycle, SS never asserted.
- SCK generation:
  - Divider counts CLK_DIV cycles per half-period. First rising edge occurs CLK_DIV cycles after SS falls.
  - One bit = 2*CLK_DIV cycles. MSB first.
  - MOSI updates on the falling edge; the first bit is set up with SS.
  - MISO is sampled in the i_clk cycle in which SCK goes 0->1.
- CMD: shifts 8 bits of 0x03, then ADDR.
- ADDR: shifts 24 bits of the latched address, then DATA. MOSI=0 during DATA.
- DATA:
  - After 8 rising edges, the assembled byte moves to o_data with o_valid=1 in the cycle after the 8th rising edge.
  - Shifting of the next byte continues while a byte is held, so there is one byte of buffering.
  - If the next byte completes while o_valid=1 and i_ready=0, enter HOLD.
- HOLD: SCK held low, SS held low, divider frozen. Resume on the cycle o_valid&i_ready: transfer the pending byte to o_data and continue.
- o_valid stays high and o_data stable until o_valid&i_ready.
- Last byte: after its 8th rising edge, enter TAIL.
- TAIL:
  - Wait one SCK half-period with SCK low, then raise SS. SS rises regardless of o_valid.
  - Then enter GAP.
- GAP:
  - SS high for SS_IDLE cycles, and the last byte has been accepted: o_busy=0 and o_done=1 for one cycle; return to IDLE.
- Byte counter decrements once per completed byte. The address is internal to the flash and does not wrap in this block. i_len up to 2^LEN_W-1 is supported.
- i_start while o_busy=1 is ignored; latched address and length are unchanged.
- i_ready is ignored when o_valid=0. No o_valid is produced during CMD/ADDR.

Test Plan:
- CLK_DIV=2, i_addr=0x000100, i_len=4, flash model holds 0x11,0x22,0x33,0x44 at 0x100, i_ready=1:
  - MOSI shows 0x03,0x00,0x01,0x00 across 32 SCK rises.
  - o_data 0x11..0x44, each with one o_valid beat.
  - SS low for (32+32)*4+2 cycles; o_done 4 cycles after SS rises.
- Same read with i_ready=0 for 100 cycles after the first o_valid:
  - o_data holds 0x11.
  - SCK stops low after the 2nd byte completes.
  - After i_ready=1: bytes 0x11..0x44 delivered in order, none lost or duplicated.
- i_start with i_len=0 -> o_done pulse next cycle; o_flash_ss stays 1; o_busy never 1.
- Pulse i_start with i_addr=0x0 during ADDR phase of an active read -> ignored; MOSI address bits unchanged; byte count unchanged.
- Assert i_rst_n=0 mid-DATA (byte 2 of 4) -> same cycle SS=1, SCK=0, o_valid=0. New read at 0x100 after release returns 0x11 first.
- CLK_DIV=1, i_len=1 -> SCK period 2 cycles; single byte 0x11 correct; o_done once.

Source files
------------

// File: rtl/spi_flash_reader.sv
`default_nettype none
// spi_flash_reader: SPI mode-0 master that issues READ (0x03) plus a 24-bit
// address and streams returned bytes out on a valid/ready port.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16,
    parameter int SS_IDLE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [23:0]      i_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_flash_ss,
    output logic             o_flash_sck,
    output logic             o_flash_mosi,
    input  logic             i_flash_miso
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(SS_IDLE) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD, S_TAIL, S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div;
    logic               r_sck;
    logic               r_ss;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_tx;
    logic [4:0]         r_bit;
    logic [6:0]         r_shift;
    logic [LEN_W-1:0]   r_len;
    logic [7:0]         r_data;
    logic               r_valid;
    logic [7:0]         r_pend;
    logic               r_pend_v;
    logic [GAP_W-1:0]   r_gap;

    logic               w_run;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    logic               w_byte;
    logic [7:0]         w_byte_val;
    logic               w_accept;
    logic               w_drained;
    logic               w_last;
    logic               w_bit_wrap;
    logic               w_launch;
    logic               w_zero_done;
    logic               w_ss_rise;
    logic               w_finish;

    assign w_run      = (r_state == S_CMD) || (r_state == S_ADDR) ||
                        (r_state == S_DATA) || (r_state == S_TAIL);
    assign w_tick     = w_run && (r_div == DIV_W'(CLK_DIV - 1));
    // TAIL only lets SCK fall; the following low half-period ends in SS rising
    assign w_rise     = w_tick && !r_sck && (r_state != S_TAIL);
    assign w_fall     = w_tick && r_sck;
    assign w_byte     = (r_state == S_DATA) && w_rise && (r_bit == 5'd7);
    assign w_byte_val = {r_shift, i_flash_miso};
    assign w_accept   = r_valid && i_ready;
    assign w_drained  = !r_valid || (i_ready && !r_pend_v);
    assign w_last     = (r_len == LEN_W'(1));
    assign w_bit_wrap = ((r_state == S_CMD)  && (r_bit == 5'd7))  ||
                        ((r_state == S_ADDR) && (r_bit == 5'd23)) ||
                        ((r_state == S_DATA) && (r_bit == 5'd7));

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_zero_done = 1'b0;
        w_ss_rise   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_CMD;
                    end else begin
                        w_zero_done = 1'b1;
                    end
                end
            end
            S_CMD:  if (w_rise && r_bit == 5'd7)  w_state_nxt = S_ADDR;
            S_ADDR: if (w_rise && r_bit == 5'd23) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_byte && w_last)
                    w_state_nxt = S_TAIL;
                else if (w_fall && r_pend_v && !w_accept)
                    w_state_nxt = S_HOLD;
            end
            S_HOLD: if (w_accept) w_state_nxt = S_DATA;
            S_TAIL: begin
                if (w_tick && !r_sck) begin
                    w_ss_rise   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_W'(SS_IDLE - 1) && w_drained) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div    <= '0;
            r_sck    <= 1'b0;
            r_ss     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tx     <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_len    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_gap    <= '0;
        end else begin
            r_done <= w_zero_done || w_finish;

            if (!w_run || w_tick) r_div <= '0;
            else                  r_div <= r_div + DIV_W'(1);

            if (w_rise)      r_sck <= 1'b1;
            else if (w_fall) r_sck <= 1'b0;

            if (w_launch)       r_ss <= 1'b0;
            else if (w_ss_rise) r_ss <= 1'b1;

            if (w_launch)      r_busy <= 1'b1;
            else if (w_finish) r_busy <= 1'b0;

            // Zeros shift in behind the address, so MOSI idles low during DATA
            if (w_launch)    r_tx <= {8'h03, i_addr};
            else if (w_fall) r_tx <= {r_tx[30:0], 1'b0};

            if (w_launch)    r_bit <= '0;
            else if (w_rise) r_bit <= w_bit_wrap ? 5'd0 : r_bit + 5'd1;

            if ((r_state == S_DATA) && w_rise) r_shift <= w_byte_val[6:0];

            if (w_launch)    r_len <= i_len;
            else if (w_byte) r_len <= r_len - LEN_W'(1);

            if (w_byte) begin
                if (!r_valid || i_ready) begin
                    r_data  <= w_byte_val;
                    r_valid <= 1'b1;
                end else begin
                    r_pend   <= w_byte_val;
                    r_pend_v <= 1'b1;
                end
            end else if (w_accept) begin
                if (r_pend_v) begin
                    r_data   <= r_pend;
                    r_pend_v <= 1'b0;
                end else begin
                    r_valid <= 1'b0;
                end
            end

            if (r_state != S_GAP)                  r_gap <= '0;
            else if (r_gap != GAP_W'(SS_IDLE - 1)) r_gap <= r_gap + GAP_W'(1);
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_flash_ss   = r_ss;
    assign o_flash_sck  = r_sck;
    assign o_flash_mosi = r_tx[31];

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// tb_spi_flash_reader: directed bench with a behavioural SPI flash and a
// byte scoreboard; two DUTs (CLK_DIV=2 and CLK_DIV=1) share one flash model.
module tb_spi_flash_reader;
    localparam int SS_IDLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [23:0] addr;
    logic [15:0] len;
    logic        ready;
    logic        miso = 1'b0;
    logic        sel;

    logic        busy0, done0, valid0, ss0, sck0, mosi0;
    logic        busy1, done1, valid1, ss1, sck1, mosi1;
    logic [7:0]  data0, data1;

    logic        m_busy, m_done, m_valid, m_ss, m_sck, m_mosi;
    logic [7:0]  m_data;

    always #5 clk = ~clk;

    spi_flash_reader #(.CLK_DIV(2), .LEN_W(16), .SS_IDLE(SS_IDLE)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_addr(addr),
        .i_len(len), .o_busy(busy0), .o_done(done0), .o_data(data0),
        .o_valid(valid0), .i_ready(ready), .o_flash_ss(ss0),
        .o_flash_sck(sck0), .o_flash_mosi(mosi0), .i_flash_miso(miso));

    spi_flash_reader #(.CLK_DIV(1), .LEN_W(16), .SS_IDLE(SS_IDLE)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_addr(addr),
        .i_len(len), .o_busy(busy1), .o_done(done1), .o_data(data1),
        .o_valid(valid1), .i_ready(ready), .o_flash_ss(ss1),
        .o_flash_sck(sck1), .o_flash_mosi(mosi1), .i_flash_miso(miso));

    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_valid = sel ? valid1 : valid0;
    assign m_data  = sel ? data1  : data0;
    assign m_ss    = sel ? ss1    : ss0;
    assign m_sck   = sel ? sck1   : sck0;
    assign m_mosi  = sel ? mosi1  : mosi0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural flash: 32 header bits in on SCK rise, data out on SCK fall
    logic [7:0]  mem [0:511];
    int          fl_bits = 0;
    int          fl_mosi_bad = 0;
    logic [31:0] fl_hdr = '0;
    logic [31:0] hdr_cap = '0;

    always @(posedge m_sck or posedge m_ss) begin
        if (m_ss) begin
            fl_bits = 0;
        end else begin
            if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], m_mosi};
            else if (m_mosi)  fl_mosi_bad++;
            fl_bits++;
            if (fl_bits == 32) hdr_cap = fl_hdr;
        end
    end

    always @(negedge m_sck) begin
        if (!m_ss && fl_bits >= 32) begin
            automatic int         k = fl_bits - 32;
            automatic logic [8:0] a = fl_hdr[8:0] + 9'(k / 8);
            automatic logic [7:0] b = mem[a];
            miso = b[7 - (k % 8)];
        end
    end

    // Scoreboard and timing monitor
    logic [7:0] exp_q[$];
    int   cyc = 0;
    int   beats, done_cnt, done_cyc, rise_cnt, first_rise, second_rise;
    int   ss_fall, ss_rise;
    logic busy_seen;
    logic prev_hold = 1'b0, prev_ss = 1'b1, prev_sck = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_ss   = 1'b1;
            prev_sck  = 1'b0;
        end else begin
            if (prev_ss && !m_ss) ss_fall = cyc;
            if (!prev_ss && m_ss) ss_rise = cyc;
            if (!prev_sck && m_sck) begin
                rise_cnt++;
                if (rise_cnt == 1)      first_rise  = cyc;
                else if (rise_cnt == 2) second_rise = cyc;
            end
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_busy) busy_seen = 1'b1;
            if (prev_hold) check("hold_stable", {m_valid, m_data}, {1'b1, prev_data});
            if (m_valid && ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", m_data);
                end else begin
                    check("byte", m_data, exp_q.pop_front());
                end
            end
            prev_hold = m_valid && !ready;
            prev_data = m_data;
            prev_ss   = m_ss;
            prev_sck  = m_sck;
        end
    end

    task automatic clear_stats();
        beats = 0; done_cnt = 0; done_cyc = -1; rise_cnt = 0;
        first_rise = -1; second_rise = -1; ss_fall = -1; ss_rise = -1;
        busy_seen = 1'b0; hdr_cap = '0; fl_mosi_bad = 0;
    endtask

    task automatic push_bytes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[9'h100 + 9'(i)]);
    endtask

    task automatic start_read(input logic [23:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        addr = a; len = l;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: o_done not seen within %0d cycles, expected a pulse", name, budget);
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: o_valid not seen within %0d cycles, expected 1", name, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[9'h100] = 8'h11; mem[9'h101] = 8'h22;
        mem[9'h102] = 8'h33; mem[9'h103] = 8'h44;
        rst_n = 1'b0; sel = 1'b0; ready = 1'b1;
        start0 = 1'b0; start1 = 1'b0; addr = '0; len = '0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss0",    ss0,    1);
        check("rst_sck0",   sck0,   0);
        check("rst_mosi0",  mosi0,  0);
        check("rst_outs0",  {busy0, done0, valid0}, 0);
        check("rst_data0",  data0,  8'h00);
        check("rst_ss1",    ss1,    1);
        check("rst_outs1",  {busy1, done1, valid1, sck1}, 0);
        rst_n = 1'b1;

        // Basic 4-byte read, CLK_DIV=2, consumer always ready
        clear_stats();
        push_bytes(4);
        start_read(24'h000100, 16'd4);
        wait_done("t1_done", 2000);
        check("t1_header",     hdr_cap, 32'h0300_0100);
        check("t1_ss_low",     ss_rise - ss_fall, (32 + 32) * 4 + 2);
        check("t1_done_delay", done_cyc - ss_rise, SS_IDLE);
        check("t1_first_rise", first_rise - ss_fall, 2);
        check("t1_rises",      rise_cnt, 64);
        check("t1_beats",      beats, 4);
        check("t1_done_cnt",   done_cnt, 1);
        check("t1_q_empty",    exp_q.size(), 0);
        check("t1_mosi_data",  fl_mosi_bad, 0);
        check("t1_busy_end",   m_busy, 0);

        // Back-pressure: consumer stalls for 100 cycles from the first byte
        clear_stats();
        push_bytes(4);
        ready = 1'b0;
        start_read(24'h000100, 16'd4);
        wait_valid("t2_valid", 2000);
        repeat (100) @(posedge clk);
        #1;
        check("t2_hold_data",  m_data, 8'h11);
        check("t2_hold_valid", m_valid, 1);
        check("t2_sck_low",    m_sck, 0);
        check("t2_rises",      rise_cnt, 48);
        check("t2_ss_low",     m_ss, 0);
        ready = 1'b1;
        wait_done("t2_done", 2000);
        check("t2_beats",    beats, 4);
        check("t2_q_empty",  exp_q.size(), 0);
        check("t2_done_cnt", done_cnt, 1);

        // Zero-length request
        clear_stats();
        start_read(24'h000100, 16'd0);
        check("t3_done",     m_done, 1);
        check("t3_busy",     m_busy, 0);
        check("t3_ss",       m_ss, 1);
        @(posedge clk); #1;
        check("t3_done_off", m_done, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t3_busy_seen", busy_seen, 0);
        check("t3_done_cnt",  done_cnt, 1);
        check("t3_no_sck",    rise_cnt, 0);

        // Start pulse during ADDR is ignored
        clear_stats();
        push_bytes(4);
        start_read(24'h000100, 16'd4);
        repeat (60) @(posedge clk);
        #1;
        addr = 24'h000000; len = 16'd2; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done("t4_done", 2000);
        check("t4_header",   hdr_cap, 32'h0300_0100);
        check("t4_beats",    beats, 4);
        check("t4_q_empty",  exp_q.size(), 0);
        check("t4_done_cnt", done_cnt, 1);

        // Asynchronous reset in the middle of the second data byte
        clear_stats();
        push_bytes(4);
        start_read(24'h000100, 16'd4);
        wait_valid("t5_valid", 2000);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ss",    m_ss, 1);
        check("t5_rst_sck",   m_sck, 0);
        check("t5_rst_valid", m_valid, 0);
        check("t5_rst_busy",  m_busy, 0);
        check("t5_beats_pre", beats, 1);
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        clear_stats();
        push_bytes(2);
        start_read(24'h000100, 16'd2);
        wait_done("t5_done", 2000);
        check("t5_header",   hdr_cap, 32'h0300_0100);
        check("t5_beats",    beats, 2);
        check("t5_q_empty",  exp_q.size(), 0);
        check("t5_done_cnt", done_cnt, 1);

        // CLK_DIV=1, single byte
        sel = 1'b1;
        clear_stats();
        push_bytes(1);
        start_read(24'h000100, 16'd1);
        wait_done("t6_done", 2000);
        check("t6_sck_period", second_rise - first_rise, 2);
        check("t6_first_rise", first_rise - ss_fall, 1);
        check("t6_ss_low",     ss_rise - ss_fall, 2 * 40 + 1);
        check("t6_done_delay", done_cyc - ss_rise, SS_IDLE);
        check("t6_beats",      beats, 1);
        check("t6_q_empty",    exp_q.size(), 0);
        check("t6_done_cnt",   done_cnt, 1);
        check("t6_dut0_idle",  {ss0, busy0}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
